// File: rtl/ex_mem_pkg.sv
// Shared widths, NOP values and stall bit positions for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int AluOpBus   = 8;

  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;

  localparam int StallEx  = 3;
  localparam int StallMem = 4;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
    logic [AluOpBus-1:0]   aluop;
    logic [RegBus-1:0]     mem_addr;
    logic [RegBus-1:0]     reg2;
  } mem_stage_t;

  typedef struct packed {
    logic                  we;
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } cp0_wr_t;

  localparam mem_stage_t MemStageNop = '{
    wd:       NOPRegAddr,
    wreg:     WriteDisable,
    wdata:    ZeroWord,
    hi:       ZeroWord,
    lo:       ZeroWord,
    whilo:    WriteDisable,
    aluop:    '0,
    mem_addr: ZeroWord,
    reg2:     ZeroWord
  };

  localparam cp0_wr_t Cp0Nop = '{we: WriteDisable, addr: NOPRegAddr, data: ZeroWord};

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush, bubble insertion and madd/msub partial-result loopback.
// Optional feature: define EX_MEM_CP0_PASS_EN to carry CP0 write requests into MEM.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [RegAddrBus-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [RegBus-1:0]     ex_wdata,
  input  logic [RegBus-1:0]     ex_hi,
  input  logic [RegBus-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [AluOpBus-1:0]   ex_aluop,
  input  logic [RegBus-1:0]     ex_mem_addr,
  input  logic [RegBus-1:0]     ex_reg2,
  input  logic [63:0]           hilo_i,
  input  logic [1:0]            cnt_i,
  input  logic                  ex_cp0_reg_we,
  input  logic [RegAddrBus-1:0] ex_cp0_reg_write_addr,
  input  logic [RegBus-1:0]     ex_cp0_reg_data,
  output logic [RegAddrBus-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [RegBus-1:0]     mem_wdata,
  output logic [RegBus-1:0]     mem_hi,
  output logic [RegBus-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [AluOpBus-1:0]   mem_aluop,
  output logic [RegBus-1:0]     mem_mem_addr,
  output logic [RegBus-1:0]     mem_reg2,
  output logic                  mem_cp0_reg_we,
  output logic [RegAddrBus-1:0] mem_cp0_reg_write_addr,
  output logic [RegBus-1:0]     mem_cp0_reg_data,
  output logic [63:0]           hilo_o,
  output logic [1:0]            cnt_o
);

  mem_stage_t ex_stage;
  mem_stage_t stage_d, stage_q;
  logic [63:0] hilo_d, hilo_q;
  logic [1:0]  cnt_d, cnt_q;

  // Only the EX and MEM stall bits matter to this stage.
  logic stall_unused;
  assign stall_unused = ^{stall[5], stall[2:0]};

  always_comb begin
    ex_stage = '{
      wd:       ex_wd,
      wreg:     ex_wreg,
      wdata:    ex_wdata,
      hi:       ex_hi,
      lo:       ex_lo,
      whilo:    ex_whilo,
      aluop:    ex_aluop,
      mem_addr: ex_mem_addr,
      reg2:     ex_reg2
    };
  end

  // EX running with MEM stalled cannot occur; it falls through to advance.
  always_comb begin
    stage_d = stage_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    if (flush) begin
      stage_d = MemStageNop;
      hilo_d  = '0;
      cnt_d   = '0;
    end else if (!stall[StallEx]) begin
      stage_d = ex_stage;
      hilo_d  = '0;
      cnt_d   = '0;
    end else if (!stall[StallMem]) begin
      stage_d = MemStageNop;
      hilo_d  = hilo_i;
      cnt_d   = cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= MemStageNop;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd       = stage_q.wd;
  assign mem_wreg     = stage_q.wreg;
  assign mem_wdata    = stage_q.wdata;
  assign mem_hi       = stage_q.hi;
  assign mem_lo       = stage_q.lo;
  assign mem_whilo    = stage_q.whilo;
  assign mem_aluop    = stage_q.aluop;
  assign mem_mem_addr = stage_q.mem_addr;
  assign mem_reg2     = stage_q.reg2;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

`ifdef EX_MEM_CP0_PASS_EN
  cp0_wr_t cp0_d, cp0_q;

  always_comb begin
    cp0_d = cp0_q;
    if (flush) begin
      cp0_d = Cp0Nop;
    end else if (!stall[StallEx]) begin
      cp0_d = '{we: ex_cp0_reg_we, addr: ex_cp0_reg_write_addr, data: ex_cp0_reg_data};
    end else if (!stall[StallMem]) begin
      cp0_d = Cp0Nop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cp0_q <= Cp0Nop;
    end else begin
      cp0_q <= cp0_d;
    end
  end

  assign mem_cp0_reg_we         = cp0_q.we;
  assign mem_cp0_reg_write_addr = cp0_q.addr;
  assign mem_cp0_reg_data       = cp0_q.data;
`else
  logic cp0_unused;
  assign cp0_unused = ^{ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data};

  assign mem_cp0_reg_we         = Cp0Nop.we;
  assign mem_cp0_reg_write_addr = Cp0Nop.addr;
  assign mem_cp0_reg_data       = Cp0Nop.data;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed table-driven bench for ex_mem; CP0 expectations follow EX_MEM_CP0_PASS_EN.
module tb_ex_mem;
  import ex_mem_pkg::*;

`ifdef EX_MEM_CP0_PASS_EN
  localparam bit Cp0En = 1'b1;
`else
  localparam bit Cp0En = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [5:0]            stall;
  logic                  flush;
  logic [RegAddrBus-1:0] ex_wd;
  logic                  ex_wreg;
  logic [RegBus-1:0]     ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic                  ex_whilo;
  logic [AluOpBus-1:0]   ex_aluop;
  logic [63:0]           hilo_i;
  logic [1:0]            cnt_i;
  logic                  ex_cp0_reg_we;
  logic [RegAddrBus-1:0] ex_cp0_reg_write_addr;
  logic [RegBus-1:0]     ex_cp0_reg_data;
  logic [RegAddrBus-1:0] mem_wd;
  logic                  mem_wreg;
  logic [RegBus-1:0]     mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic                  mem_whilo;
  logic [AluOpBus-1:0]   mem_aluop;
  logic                  mem_cp0_reg_we;
  logic [RegAddrBus-1:0] mem_cp0_reg_write_addr;
  logic [RegBus-1:0]     mem_cp0_reg_data;
  logic [63:0]           hilo_o;
  logic [1:0]            cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .ex_cp0_reg_we(ex_cp0_reg_we), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
    .ex_cp0_reg_data(ex_cp0_reg_data),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
    .mem_cp0_reg_data(mem_cp0_reg_data),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic        cp0_we;
    logic [31:0] cp0_data;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
    logic        e_cp0_we;
    logic [31:0] e_cp0_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rot(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Side fields are derived from wd/wreg/wdata so every output carries a distinct, checkable value.
  task automatic drive(input logic r, input logic f, input logic [5:0] s, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata, input logic [63:0] hi_i,
                       input logic [1:0] c_i, input logic cwe, input logic [31:0] cdata);
    rst = r; flush = f; stall = s;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_hi = rot(wdata, 16); ex_lo = rot(wdata, 8); ex_whilo = wreg;
    ex_aluop = wdata[11:4]; ex_mem_addr = rot(wdata, 4); ex_reg2 = rot(wdata, 24);
    hilo_i = hi_i; cnt_i = c_i;
    ex_cp0_reg_we = cwe; ex_cp0_reg_write_addr = wd; ex_cp0_reg_data = cdata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_wd, input logic e_wreg,
                         input logic [31:0] e_wdata, input logic [63:0] e_hilo,
                         input logic [1:0] e_cnt, input logic e_cwe, input logic [31:0] e_cdata);
    chk({tag, " mem_wd"},       64'(mem_wd),       64'(e_wd));
    chk({tag, " mem_wreg"},     64'(mem_wreg),     64'(e_wreg));
    chk({tag, " mem_wdata"},    64'(mem_wdata),    64'(e_wdata));
    chk({tag, " mem_hi"},       64'(mem_hi),       64'(rot(e_wdata, 16)));
    chk({tag, " mem_lo"},       64'(mem_lo),       64'(rot(e_wdata, 8)));
    chk({tag, " mem_whilo"},    64'(mem_whilo),    64'(e_wreg));
    chk({tag, " mem_aluop"},    64'(mem_aluop),    64'(e_wdata[11:4]));
    chk({tag, " mem_mem_addr"}, 64'(mem_mem_addr), 64'(rot(e_wdata, 4)));
    chk({tag, " mem_reg2"},     64'(mem_reg2),     64'(rot(e_wdata, 24)));
    chk({tag, " hilo_o"},       hilo_o,            e_hilo);
    chk({tag, " cnt_o"},        64'(cnt_o),        64'(e_cnt));
    chk({tag, " cp0_we"},       64'(mem_cp0_reg_we),         Cp0En ? 64'(e_cwe) : 64'd0);
    chk({tag, " cp0_addr"},     64'(mem_cp0_reg_write_addr), Cp0En ? 64'(e_wd) : 64'd0);
    chk({tag, " cp0_data"},     64'(mem_cp0_reg_data),       Cp0En ? 64'(e_cdata) : 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                rst   flush stall      wd     wreg  wdata         hilo_i                  cnt    cwe   cdata         | e_wd  e_wreg e_wdata       e_hilo                  e_cnt  e_cwe e_cdata
    vecs.push_back('{1'b0, 1'b1, 6'b111111, 5'h1f, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 1'b1, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0,        64'h0,                  2'd0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b000000, 5'd3,  1'b1, 32'h12345678, 64'h0,                  2'd0, 1'b0, 32'h0,        5'd3, 1'b1, 32'h12345678, 64'h0,                  2'd0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b001111, 5'd7,  1'b1, 32'hCAFEF00D, 64'h00000001_FFFFFFFE, 2'd1, 1'b1, 32'h55,       5'd0, 1'b0, 32'h0,        64'h00000001_FFFFFFFE, 2'd1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b000000, 5'd9,  1'b1, 32'hA5A5A5A5, 64'h77,                 2'd2, 1'b1, 32'hDEADBEEF, 5'd9, 1'b1, 32'hA5A5A5A5, 64'h0,                  2'd0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 6'b011111, 5'd1,  1'b0, 32'h11111111, 64'h1,                  2'd1, 1'b0, 32'h1,        5'd9, 1'b1, 32'hA5A5A5A5, 64'h0,                  2'd0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 6'b011111, 5'd2,  1'b1, 32'h22222222, 64'h2,                  2'd2, 1'b1, 32'h2,        5'd9, 1'b1, 32'hA5A5A5A5, 64'h0,                  2'd0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 6'b011111, 5'd3,  1'b0, 32'h33333333, 64'h3,                  2'd3, 1'b0, 32'h3,        5'd9, 1'b1, 32'hA5A5A5A5, 64'h0,                  2'd0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 6'b001111, 5'd4,  1'b1, 32'h44444444, 64'hABCD,               2'd2, 1'b1, 32'h4,        5'd0, 1'b0, 32'h0,        64'hABCD,               2'd2, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b011111, 5'd5,  1'b1, 32'h55555555, 64'h5,                  2'd1, 1'b1, 32'h5,        5'd0, 1'b0, 32'h0,        64'hABCD,               2'd2, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 6'b001111, 5'd6,  1'b1, 32'h5,        64'h9,                  2'd3, 1'b1, 32'h6,        5'd0, 1'b0, 32'h0,        64'h0,                  2'd0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b010000, 5'd4,  1'b0, 32'h0BADC0DE, 64'h8,                  2'd1, 1'b0, 32'h7,        5'd4, 1'b0, 32'h0BADC0DE, 64'h0,                  2'd0, 1'b0, 32'h7});
    vecs.push_back('{1'b1, 1'b0, 6'b001111, 5'd8,  1'b1, 32'h88888888, 64'h12345678_9ABCDEF0, 2'd3, 1'b1, 32'h8,        5'd0, 1'b0, 32'h0,        64'h12345678_9ABCDEF0, 2'd3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'd10, 1'b1, 32'h99999999, 64'h1,                  2'd1, 1'b1, 32'h9,        5'd0, 1'b0, 32'h0,        64'h0,                  2'd0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b001111, 5'd11, 1'b1, 32'h77777777, 64'h42,                 2'd1, 1'b1, 32'hA,        5'd0, 1'b0, 32'h0,        64'h42,                 2'd1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 6'b000000, 5'd0,  1'b0, 32'h0,        64'h0,                  2'd0, 1'b1, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0,        64'h0,                  2'd0, 1'b1, 32'hDEADBEEF});

    drive(1'b0, 1'b0, 6'b0, 5'd0, 1'b0, 32'h0, 64'h0, 2'd0, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].wd, vecs[i].wreg, vecs[i].wdata,
            vecs[i].hilo_i, vecs[i].cnt_i, vecs[i].cp0_we, vecs[i].cp0_data);
      if (vecs[i].rst && !vecs[i].flush && !vecs[i].stall[StallEx] && vecs[i].stall[StallMem])
        $display("NOTE: vector %0d drives illegal stall pattern (EX running, MEM stalled); expecting advance", i);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_wd, vecs[i].e_wreg, vecs[i].e_wdata,
              vecs[i].e_hilo, vecs[i].e_cnt, vecs[i].e_cp0_we, vecs[i].e_cp0_data);
    end

    // No combinational path: new EX inputs must not show until the next rising edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 6'b000000, 5'd5, 1'b1, 32'h600DCAFE, 64'h0, 2'd0, 1'b1, 32'h13579BDF);
    #1;
    chk("comb mem_wdata", 64'(mem_wdata), 64'h0);
    chk("comb mem_wreg",  64'(mem_wreg),  64'h0);
    @(posedge clk);
    #1;
    chk_all("latency", 5'd5, 1'b1, 32'h600DCAFE, 64'h0, 2'd0, 1'b1, 32'h13579BDF);

    // Reset wins over a hold request; the following flush+hold edge stays cleared.
    @(negedge clk);
    drive(1'b0, 1'b0, 6'b011111, 5'd6, 1'b1, 32'h1234ABCD, 64'h5, 2'd2, 1'b1, 32'h1);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 5'd0, 1'b0, 32'h0, 64'h0, 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 6'b011111, 5'd6, 1'b1, 32'h1234ABCD, 64'h5, 2'd2, 1'b1, 32'h1);
    @(posedge clk);
    #1;
    chk_all("flush_hold", 5'd0, 1'b0, 32'h0, 64'h0, 2'd0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have no parameters; widths come from the shared defines (RegAddrBus=5, RegBus=32, AluOpBus=8).
REQ-002 SHALL use a single clock and a synchronous, active-low reset: clk in 1, rising-edge clock.
REQ-003 rst  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 stall  in  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled.
REQ-005 flush  in  1  exception flush; clears all stage contents.
REQ-006 ex_wd in 5 / ex_wreg in 1 / ex_wdata in 32  GPR write destination, enable and data from EX.
REQ-007 ex_hi in 32 / ex_lo in 32 / ex_whilo in 1  HI/LO write data and enable from EX.
REQ-008 ex_aluop in 8 / ex_mem_addr in 32 / ex_reg2 in 32  load/store opcode, effective address and store operand.
REQ-009 hilo_i in 64 / cnt_i in 2  multi-cycle (madd/msub) partial result and cycle count from EX.
REQ-010 ex_cp0_reg_we in 1 / ex_cp0_reg_write_addr in 5 / ex_cp0_reg_data in 32  CP0 write request.
REQ-011 mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  registered copies of REQ-006..008 inputs, same widths, to MEM.
REQ-012 mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data  out  registered copies of REQ-010 inputs, same widths.
REQ-013 hilo_o out 64 / cnt_o out 2  partial result and count returned to EX.

Function
REQ-014 All outputs SHALL be registers updated only on rising clk; no combinational input-to-output path.
REQ-015 Priority per edge SHALL be: reset > flush > bubble > advance > hold.
REQ-016 flush=1: all outputs SHALL load zero (mem_wd=NOPRegAddr=0, enables WriteDisable), hilo_o=0, cnt_o=0.
REQ-017 Bubble (stall[3]=1, stall[4]=0): MEM outputs SHALL load zero; hilo_o SHALL load hilo_i and cnt_o SHALL load cnt_i.
REQ-018 Advance (stall[3]=0): all MEM outputs SHALL load their ex_* inputs; hilo_o and cnt_o SHALL load zero.
REQ-019 Hold (stall[3]=1, stall[4]=1): every output SHALL keep its value.
REQ-020 stall[3]=0 with stall[4]=1 is illegal; the block SHALL treat it as advance, and the bench SHALL flag it.
REQ-021 Latency SHALL be exactly one cycle from an ex_* input to the corresponding mem_* output.
REQ-022 A bubble SHALL never present a non-zero write enable (GPR, HI/LO, CP0) downstream.
REQ-023 flush in the same cycle as any stall SHALL still clear the stage, including hilo_o and cnt_o.

Reset
REQ-024 rst=0 at a rising edge SHALL zero every output, including hilo_o and cnt_o, regardless of stall/flush.
REQ-025 Reset asserted mid-madd (cnt_o≠0) SHALL discard the partial result; the first edge after rst=1 SHALL follow REQ-015.

Configuration
REQ-026 Macro EX_MEM_CP0_PASS_EN defined: the CP0 fields SHALL be registered per REQ-016..019.
REQ-027 EX_MEM_CP0_PASS_EN undefined: the CP0 input ports SHALL still exist but be ignored, and the CP0 outputs SHALL be constant zero.

Structure
REQ-028 RegAddrBus, RegBus, AluOpBus, NOPRegAddr, ZeroWord, WriteEnable/WriteDisable and the stall bit indices SHALL come from the shared defines package; no local redefinition.
REQ-029 Structure SHALL be a single flat module with no sub-modules.

Verification
REQ-030 Reset: drive rst=0 with all inputs at 0xFFFFFFFF, then one edge -> all outputs 0.
REQ-031 Advance: ex_wd=5'd3, ex_wreg=1, ex_wdata=0x12345678, stall=0 -> next edge mem_wd=3, mem_wreg=1, mem_wdata=0x12345678, cnt_o=0.
REQ-032 Bubble: stall=6'b001111, hilo_i=0x0000_0001_FFFF_FFFE, cnt_i=2'b01 -> mem_wreg=0, mem_wdata=0, hilo_o=0x0000_0001_FFFF_FFFE, cnt_o=1.
REQ-033 Hold: stall=6'b011111 for 3 cycles after loading mem_wdata=0xA5A5A5A5 -> value unchanged for all 3 cycles despite changing inputs.
REQ-034 Flush: flush=1 with stall=6'b001111 and ex_wreg=1 -> all outputs 0 next edge, cnt_o=0.
REQ-035 Config: ex_cp0_reg_we=1, ex_cp0_reg_data=0xDEADBEEF, stall=0 -> mem_cp0_reg_data=0xDEADBEEF with EX_MEM_CP0_PASS_EN defined, 0 without it.
